// File: rtl/bht_pkg.sv
// Shared definitions for the branch history table: default widths, the
// 2-bit counter encodings and the saturating counter update.
package bht_pkg;

   localparam int unsigned DEF_ADDR_W = 10;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_state_e;

   function automatic logic [1:0] sat_next(input logic [1:0] old, input logic taken);
      if (taken)
         return (old == ST) ? ST : old + 2'd1;
      else
         return (old == SNT) ? SNT : old - 2'd1;
   endfunction

endpackage

// File: rtl/bht_lru.sv
// True-LRU age tracker: each entry holds an age, 0 = most recently used,
// ENTRIES-1 = least recently used; ages always form a permutation.
module bht_lru #(
   parameter int unsigned ENTRIES = 8,
   parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             touch_en,
   input  logic [IDX_W-1:0] touch_idx,
   output logic [IDX_W-1:0] lru_idx
);

   logic [IDX_W-1:0] age [ENTRIES];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < ENTRIES; i++)
            age[i] <= IDX_W'(i);
      end else if (touch_en) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (IDX_W'(i) == touch_idx)
               age[i] <= '0;
            else if (age[i] < age[touch_idx])
               age[i] <= age[i] + 1'b1;
         end
      end
   end

   always_comb begin
      lru_idx = '0;
      for (int unsigned i = 0; i < ENTRIES; i++)
         if (age[i] == IDX_W'(ENTRIES - 1))
            lru_idx = IDX_W'(i);
   end

endmodule

// File: rtl/syn_bht.sv
// Fully-associative branch history table with target buffer: zero-latency
// lookup for fetch, write-back from execute, true-LRU replacement.
module syn_bht
   import bht_pkg::*;
#(
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned ENTRIES = 8,
   parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              update_en,
   input  logic [ADDR_W-1:0] update_pc_4,
   input  logic [ADDR_W-1:0] update_pc_remote,
   input  logic [1:0]        update_state_old,
   input  logic              branch_succ,
   input  logic [ADDR_W-1:0] pc_4,
   output logic [ADDR_W-1:0] guess_new_pc,
   output logic [1:0]        guess_state
);

   logic              valid  [ENTRIES];
   logic [ADDR_W-1:0] tag    [ENTRIES];
   logic [ADDR_W-1:0] target [ENTRIES];
   logic [1:0]        state  [ENTRIES];

   logic              hit;
   logic [IDX_W-1:0]  hit_idx;
   logic              upd_hit;
   logic [IDX_W-1:0]  upd_idx;
   logic              free_found;
   logic [IDX_W-1:0]  free_idx;
   logic [IDX_W-1:0]  lru_idx;
   logic [IDX_W-1:0]  wr_idx;

   // Fetch-side CAM
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         if (valid[i] && tag[i] == pc_4) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      guess_state  = hit ? state[hit_idx] : SNT;
      guess_new_pc = (hit && state[hit_idx][1]) ? target[hit_idx] : pc_4;
   end

   // Write-back CAM and victim choice; descending scan leaves the lowest free index
   always_comb begin
      upd_hit    = 1'b0;
      upd_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int unsigned i = ENTRIES; i > 0; i--) begin
         if (valid[i-1] && tag[i-1] == update_pc_4) begin
            upd_hit = 1'b1;
            upd_idx = IDX_W'(i - 1);
         end
         if (!valid[i-1]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i - 1);
         end
      end
      if (upd_hit)
         wr_idx = upd_idx;
      else if (free_found)
         wr_idx = free_idx;
      else
         wr_idx = lru_idx;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid[i]  <= 1'b0;
            tag[i]    <= '0;
            target[i] <= '0;
            state[i]  <= SNT;
         end
      end else if (update_en) begin
         valid[wr_idx]  <= 1'b1;
         tag[wr_idx]    <= update_pc_4;
         target[wr_idx] <= update_pc_remote;
         state[wr_idx]  <= sat_next(update_state_old, branch_succ);
      end
   end

   bht_lru #(
      .ENTRIES (ENTRIES),
      .IDX_W   (IDX_W)
   ) u_lru (
      .clk       (clk),
      .rst_n     (rst_n),
      .touch_en  (update_en),
      .touch_idx (wr_idx),
      .lru_idx   (lru_idx)
   );

endmodule

// File: tb/tb_syn_bht.sv
// Self-checking bench for syn_bht: directed scenarios plus random traffic,
// compared against a recency-ordered list model of the table.
module tb_syn_bht;

   localparam int unsigned AW = 10;
   localparam int unsigned NE = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          update_en;
   logic [AW-1:0] update_pc_4;
   logic [AW-1:0] update_pc_remote;
   logic [1:0]    update_state_old;
   logic          branch_succ;
   logic [AW-1:0] pc_4;
   logic [AW-1:0] guess_new_pc;
   logic [1:0]    guess_state;

   int checks   = 0;
   int failures = 0;

   logic [AW-1:0] obs_pc;
   logic [1:0]    obs_st;

   typedef struct {
      logic [AW-1:0] tag;
      logic [AW-1:0] tgt;
      logic [1:0]    st;
   } ent_t;

   ent_t mdl[$];   // front = most recently written

   always #5 clk = ~clk;

   syn_bht #(
      .ADDR_W  (AW),
      .ENTRIES (NE)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .update_en        (update_en),
      .update_pc_4      (update_pc_4),
      .update_pc_remote (update_pc_remote),
      .update_state_old (update_state_old),
      .branch_succ      (branch_succ),
      .pc_4             (pc_4),
      .guess_new_pc     (guess_new_pc),
      .guess_state      (guess_state)
   );

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic model_lookup(input logic [AW-1:0] pc, output logic [AW-1:0] epc,
                               output logic [1:0] est);
      epc = pc;
      est = 2'b00;
      foreach (mdl[k])
         if (mdl[k].tag == pc) begin
            est = mdl[k].st;
            if (mdl[k].st >= 2) epc = mdl[k].tgt;
         end
   endtask

   task automatic model_update(input logic [AW-1:0] t, input logic [AW-1:0] tgt,
                               input logic [1:0] old, input logic tk);
      ent_t e;
      int   n;
      n = int'(old) + (tk ? 1 : -1);
      if (n > 3) n = 3;
      if (n < 0) n = 0;
      e.tag = t;
      e.tgt = tgt;
      e.st  = 2'(n);
      foreach (mdl[k])
         if (mdl[k].tag == t) begin
            mdl.delete(k);
            break;
         end
      if (mdl.size() == NE) void'(mdl.pop_back());
      mdl.push_front(e);
   endtask

   // One clock: drive, compare lookup against model before the edge, advance model
   task automatic step(input logic rst, input logic ue, input logic [AW-1:0] ut,
                       input logic [AW-1:0] utgt, input logic [1:0] old, input logic tk,
                       input logic [AW-1:0] pc);
      logic [AW-1:0] epc;
      logic [1:0]    est;
      rst_n            = ~rst;
      update_en        = ue;
      update_pc_4      = ut;
      update_pc_remote = utgt;
      update_state_old = old;
      branch_succ      = tk;
      pc_4             = pc;
      #1;
      obs_pc = guess_new_pc;
      obs_st = guess_state;
      model_lookup(pc, epc, est);
      check("mdl_pc", 16'(obs_pc), 16'(epc));
      check("mdl_st", 16'(obs_st), 16'(est));
      @(posedge clk);
      if (rst) mdl.delete();
      else if (ue) model_update(ut, utgt, old, tk);
      #1;
   endtask

   task automatic upd(input logic [AW-1:0] t, input logic [AW-1:0] tgt,
                      input logic [1:0] old, input logic tk);
      step(1'b0, 1'b1, t, tgt, old, tk, 10'h3ff);
   endtask

   task automatic look(input string name, input logic [AW-1:0] pc,
                       input logic [AW-1:0] epc, input logic [1:0] est);
      step(1'b0, 1'b0, '0, '0, 2'b00, 1'b0, pc);
      check({name, "_pc"}, 16'(obs_pc), 16'(epc));
      check({name, "_st"}, 16'(obs_st), 16'(est));
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, '0, '0, 2'b00, 1'b0, 10'h001);
   endtask

   initial begin
      logic [AW-1:0] t;
      rst_n = 1'b0; update_en = 1'b0; update_pc_4 = '0; update_pc_remote = '0;
      update_state_old = '0; branch_succ = 1'b0; pc_4 = 10'h001;
      @(posedge clk); #1;
      @(posedge clk); #1;

      look("rst_empty", 10'h001, 10'h001, 2'b00);

      upd(10'h001, 10'h010, 2'b10, 1'b1);
      upd(10'h001, 10'h010, 2'b10, 1'b1);
      look("taken", 10'h001, 10'h010, 2'b11);
      upd(10'h001, 10'h010, 2'b10, 1'b0);
      look("dec", 10'h001, 10'h001, 2'b01);
      upd(10'h001, 10'h010, 2'b00, 1'b0);
      look("sat_lo", 10'h001, 10'h001, 2'b00);
      upd(10'h001, 10'h010, 2'b11, 1'b1);
      look("sat_hi", 10'h001, 10'h010, 2'b11);

      do_reset();
      begin
         int seq [11] = '{1, 2, 3, 4, 2, 5, 6, 7, 8, 1, 9};
         foreach (seq[k]) upd(AW'(seq[k]), AW'(seq[k] * 16), 2'b10, 1'b1);
      end
      look("ev_keep2", 10'h002, 10'h020, 2'b11);
      look("ev_gone3", 10'h003, 10'h003, 2'b00);
      look("ev_new9", 10'h009, 10'h090, 2'b11);
      look("ev_keep1", 10'h001, 10'h010, 2'b11);

      step(1'b0, 1'b1, 10'h030, 10'h300, 2'b10, 1'b1, 10'h030);
      check("same_cyc_pc", 16'(obs_pc), 16'h0030);
      check("same_cyc_st", 16'(obs_st), 16'h0000);
      look("next_cyc", 10'h030, 10'h300, 2'b11);

      step(1'b1, 1'b1, 10'h040, 10'h123, 2'b10, 1'b1, 10'h002);
      look("mid_rst2", 10'h002, 10'h002, 2'b00);
      look("mid_rst40", 10'h040, 10'h040, 2'b00);
      for (int k = 0; k < 9; k++) upd(AW'(10'h100 + k), AW'(10'h200 + k), 2'b10, 1'b1);
      look("refill_first", 10'h100, 10'h100, 2'b00);
      look("refill_second", 10'h101, 10'h201, 2'b11);
      look("refill_last", 10'h108, 10'h208, 2'b11);

      for (int k = 0; k < 600; k++) begin
         t = AW'($urandom_range(1, 13));
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), t,
              AW'($urandom), 2'($urandom), 1'($urandom),
              ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(1, 13)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule

// File: doc/syn_bht.md
Name: syn_bht

Overview:
- Fully-associative branch history table (BHT) with branch target buffer, used by the fetch stage of the pipelined core.
- Fetch presents pc_4, the PC+1 word address of the current instruction. The block combinationally returns a predicted next PC and the 2-bit saturating-counter state for that branch.
- The execute stage writes back the resolved branch outcome. Entries are replaced by true LRU.

Parameters:
- ADDR_W, 10, instruction-memory word-address width (IM_ADDR_BIT).
- ENTRIES, 8, number of table entries; must be a power of two, at least 2.
- IDX_W, log2(ENTRIES) = 3, entry index and age-counter width (derived).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- update_en  in  1  write-back strobe for a resolved branch, sampled on each rising edge.
- update_pc_4  in  ADDR_W  tag (PC+1) of the resolved branch.
- update_pc_remote  in  ADDR_W  taken-target address of the resolved branch.
- update_state_old  in  2  counter state that was predicted for this branch at fetch.
- branch_succ  in  1  1 = branch taken, 0 = not taken.
- pc_4  in  ADDR_W  lookup tag from fetch.
- guess_new_pc  out  ADDR_W  predicted next fetch address.
- guess_state  out  2  counter state of the hit entry, or 2'b00 on a miss.

Behaviour:
- Entry contents: valid bit, tag[ADDR_W], target[ADDR_W], state[2], age[IDX_W]. Age 0 = MRU, ENTRIES-1 = LRU.
- Reset (rst_n=0 at a rising edge):
  - all valid bits cleared;
  - entry i age set to i, so ages are always a permutation of 0..ENTRIES-1;
  - tag, target and state cleared to 0.
- Outputs during and after reset follow the lookup rule below; with no valid entries: guess_new_pc = pc_4, guess_state = 2'b00.
- Lookup (purely combinational, zero latency, from registered contents):
  - hit = a valid entry has tag == pc_4. Tags are unique, so at most one entry hits.
  - On hit: guess_state = entry state; guess_new_pc = entry target if state[1]=1, else pc_4.
  - On miss: guess_state = 2'b00, guess_new_pc = pc_4.
  - Lookups never change LRU state.
- New counter state is computed from update_state_old, not from the stored state, so repeated identical updates are idempotent:
  - branch_succ=1: new = old+1, saturating at 2'b11.
  - branch_succ=0: new = old-1, saturating at 2'b00.
- Update (rising edge with rst_n=1 and update_en=1):
  - Update hit (valid entry with tag == update_pc_4): write target = update_pc_remote and state = new; entry becomes MRU.
  - Update miss: select a victim, then write valid=1, tag = update_pc_4, target = update_pc_remote, state = new; victim becomes MRU.
  - Victim selection: the lowest-index invalid entry if one exists, otherwise the entry with age ENTRIES-1.
- LRU aging on every update:
  - let A = old age of the touched entry;
  - each other entry with age < A increments its age;
  - the touched entry's age becomes 0;
  - all other ages are unchanged.
- update_en held high for several cycles repeats the same write; the second and later cycles hit and leave the table unchanged.
- Simultaneous lookup and update, including the same tag: the lookup sees pre-edge contents; the new data is visible from the cycle after the edge.
- Reset has priority over update_en.

Decomposition:
- Package bht_pkg:
  - ADDR_W default;
  - state encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - saturating-increment/decrement function.
- Sub-module bht_lru: holds the age counters; inputs touch_en and touch_idx; outputs lru_idx.
- Top level holds the tag, target and state arrays, the two CAM comparators, and victim/write logic.

Test Plan:
- Reset, then pc_4=0x1 with an empty table -> guess_new_pc=0x1, guess_state=2'b00.
- Update tag 0x1, target 0x10, old=2'b10, taken, update_en high 2 cycles; lookup pc_4=0x1 -> guess_new_pc=0x10, guess_state=2'b11.
- Update tag 0x1, old=2'b10, not taken -> state 2'b01, guess_new_pc=0x1. Update old=2'b00 not taken -> state 2'b00. Update old=2'b11 taken -> state 2'b11.
- LRU eviction, 8 entries: update sequence tags 1,2,3,4,2,5,6,7,8,1,9 (target = tag×0x10, old=2'b10, taken). Then:
  - pc_4=2 -> 0x20 / 2'b11;
  - pc_4=3 -> 0x3 / 2'b00 (tag 3 evicted);
  - pc_4=9 -> 0x90 / 2'b11;
  - pc_4=1 -> 0x10 / 2'b11.
- Same-cycle lookup and update of the same tag on a new entry -> miss output that cycle, hit output the next cycle.
- Assert rst_n=0 mid-sequence for one edge -> all lookups miss afterwards. Refill 9 distinct tags -> tag of the first refill is evicted.
